// File: rtl/digit_serial_adder_if.sv
// Operation request / result bundle for the digit-serial adder.
interface digit_serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zero;
    logic             lsb;

    modport master (
        output start, op, a, b, ci,
        input  busy, done, s, co, ovf, zero, lsb
    );

    modport slave (
        input  start, op, a, b, ci,
        output busy, done, s, co, ovf, zero, lsb
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor/accumulator that adds DIGIT bits per clock,
// LSB slice first, and publishes the full result only on completion.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    digit_serial_adder_if.slave bus
);
    if ((DIGIT == 0) || (WIDTH == 0) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               lsb_q, lsb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT:0]       slice_full;
    logic [DIGIT-1:0]     slice_sum;
    logic                 slice_co;
    logic                 slice_msb_ci;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]     sum_next;

    // One DIGIT-wide slice of the ripple, plus the carry into its top bit for overflow.
    always_comb begin
        slice_full   = {1'b0, x_q[DIGIT-1:0]} + {1'b0, y_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};
        slice_sum    = slice_full[DIGIT-1:0];
        slice_co     = slice_full[DIGIT];
        slice_msb_ci = x_q[DIGIT-1] ^ y_q[DIGIT-1] ^ slice_sum[DIGIT-1];
        sum_cat      = {slice_sum, sum_q};
        sum_next     = sum_cat[WIDTH+DIGIT-1:DIGIT];
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_CLR) begin
                        state_d = DONE;
                        s_d     = '0;
                        co_d    = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                        x_d     = (bus.op == OP_ACC) ? s_q : bus.a;
                        y_d     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        carry_d = (bus.op == OP_SUB) ? 1'b1 : bus.ci;
                        sum_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                x_d     = x_q >> DIGIT;
                y_d     = y_q >> DIGIT;
                carry_d = slice_co;
                sum_d   = sum_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    s_d     = sum_next;
                    co_d    = slice_co;
                    ovf_d   = slice_msb_ci ^ slice_co;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        zero_d = (s_d == '0);
        lsb_d  = s_d[0];
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            lsb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            lsb_q   <= lsb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
    assign bus.lsb  = lsb_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed table, corner sequences,
// randomized operations against an arithmetic reference model.
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(8))  if8 ();
    digit_serial_adder_if #(.WIDTH(16)) if16a ();
    digit_serial_adder_if #(.WIDTH(16)) if16b ();

    digit_serial_adder #(.WIDTH(8),  .DIGIT(4)) dut     (.clk(clk), .rst(rst), .bus(if8.slave));
    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut16_4 (.clk(clk), .rst(rst), .bus(if16a.slave));
    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut16_1 (.clk(clk), .rst(rst), .bus(if16b.slave));

    int checks = 0;
    int errors = 0;
    logic [7:0] model_s;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] exp_s;
        logic       exp_co;
        logic       exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Returns {ovf, co, s} from plain integer arithmetic on the operation's meaning.
    function automatic logic [9:0] ref8(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci,
                                        input logic [7:0] sp);
        logic [7:0] x;
        int ures, sres;
        logic co, ov;
        if (op == 2'b11) return 10'd0;
        x = (op == 2'b10) ? sp : a;
        if (op == 2'b01) begin
            ures = int'(x) - int'(b);
            sres = int'($signed(x)) - int'($signed(b));
            co   = (x >= b);
        end else begin
            ures = int'(x) + int'(b) + int'(ci);
            sres = int'($signed(x)) + int'($signed(b)) + int'(ci);
            co   = (ures > 255);
        end
        ov = (sres > 127) || (sres < -128);
        return {ov, co, 8'(ures)};
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input bit hold,
                          output int edges, output int busy_cnt, output bit got);
        @(negedge clk);
        if8.start = 1'b1; if8.op = op; if8.a = a; if8.b = b; if8.ci = ci;
        edges = 0; busy_cnt = 0; got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                if (!hold) begin
                    if8.start = 1'b0;
                    if8.op    = 2'($urandom);
                end
                if8.a  = 8'($urandom);
                if8.b  = 8'($urandom);
                if8.ci = 1'($urandom);
            end
            if (if8.busy) busy_cnt++;
            if (if8.done) got = 1'b1;
        end
        if8.start = 1'b0;
    endtask

    task automatic exec(input string name, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ci, input bit hold,
                        input logic [7:0] exp_s, input logic exp_co, input logic exp_ovf);
        int edges, busy_cnt, lat;
        bit got;
        lat = (op == 2'b11) ? 1 : 3;
        run_op(op, a, b, ci, hold, edges, busy_cnt, got);
        chk({name, ".done"}, 32'(got), 32'd1);
        chk({name, ".lat"}, 32'(edges), 32'(lat));
        chk({name, ".busy"}, 32'(busy_cnt), 32'(lat));
        chk({name, ".res"}, {22'd0, if8.co, if8.ovf, if8.s}, {22'd0, exp_co, exp_ovf, exp_s});
        chk({name, ".flags"}, {30'd0, if8.zero, if8.lsb}, {30'd0, (exp_s == 8'd0), exp_s[0]});
        @(posedge clk); #1;
        chk({name, ".idle"}, {30'd0, if8.busy, if8.done}, 32'd0);
        model_s = exp_s;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci);
        int n, ea, eb, ures, sres;
        logic co, ov;
        @(negedge clk);
        if16a.start = 1'b1; if16a.op = 2'b00; if16a.a = a; if16a.b = b; if16a.ci = ci;
        if16b.start = 1'b1; if16b.op = 2'b00; if16b.a = a; if16b.b = b; if16b.ci = ci;
        n = 0; ea = 0; eb = 0;
        while ((ea == 0 || eb == 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                if16a.start = 1'b0; if16a.a = 16'($urandom);
                if16b.start = 1'b0; if16b.b = 16'($urandom);
            end
            if (if16a.done && ea == 0) ea = n;
            if (if16b.done && eb == 0) eb = n;
        end
        ures = int'(a) + int'(b) + int'(ci);
        sres = int'($signed(a)) + int'($signed(b)) + int'(ci);
        co   = (ures > 65535);
        ov   = (sres > 32767) || (sres < -32768);
        chk("w16d4.lat", 32'(ea), 32'd5);
        chk("w16d1.lat", 32'(eb), 32'd17);
        chk("w16d4.res", {14'd0, if16a.co, if16a.ovf, if16a.s}, {14'd0, co, ov, 16'(ures)});
        chk("w16d1.res", {14'd0, if16b.co, if16b.ovf, if16b.s}, {14'd0, co, ov, 16'(ures)});
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vt[8];
        logic [9:0] r;
        int n;
        bit saw_done;
        logic [1:0] op;
        logic [7:0] a, b;
        logic ci;

        vt[0] = '{2'b00, 8'h3A, 8'hC5, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[1] = '{2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{2'b00, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3] = '{2'b01, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vt[4] = '{2'b01, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[5] = '{2'b01, 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[6] = '{2'b00, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0};
        vt[7] = '{2'b01, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};

        if8.start = 1'b0;   if8.op = 2'b00;   if8.a = '0;   if8.b = '0;   if8.ci = 1'b0;
        if16a.start = 1'b0; if16a.op = 2'b00; if16a.a = '0; if16a.b = '0; if16a.ci = 1'b0;
        if16b.start = 1'b0; if16b.op = 2'b00; if16b.a = '0; if16b.b = '0; if16b.ci = 1'b0;
        model_s = 8'd0;

        rst = 1'b1;
        #1;
        chk("reset.state", {21'd0, if8.busy, if8.done, if8.s, if8.co, if8.ovf},
            {21'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        chk("reset.flags", {30'd0, if8.zero, if8.lsb}, {30'd0, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            exec($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].ci, 1'b0,
                 vt[i].exp_s, vt[i].exp_co, vt[i].exp_ovf);

        // Clear, then accumulate; operand a must be ignored and held start must not re-trigger.
        exec("clear", 2'b11, 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        exec("acc1", 2'b10, 8'h55, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        exec("acc2", 2'b10, 8'h66, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        exec("acc3", 2'b10, 8'h77, 8'h10, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an add.
        @(negedge clk);
        if8.start = 1'b1; if8.op = 2'b00; if8.a = 8'h12; if8.b = 8'h34; if8.ci = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort.async", {20'd0, if8.busy, if8.done, if8.s, if8.zero, if8.co, if8.ovf},
            {20'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        model_s = 8'd0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (if8.done || if8.busy) saw_done = 1'b1;
        end
        chk("abort.quiet", {23'd0, saw_done, if8.s}, 32'd0);
        exec("after_abort", 2'b00, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        run16(16'hFFFF, 16'h0001, 1'b0);
        run16(16'(($urandom)), 16'(($urandom)), 1'b1);

        n = 0;
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            r  = ref8(op, a, b, ci, model_s);
            exec($sformatf("rnd%0d", i), op, a, b, ci, bit'($urandom_range(0, 1)),
                 r[7:0], r[8], r[9]);
            n++;
        end
        chk("rnd.count", 32'(n), 32'd150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
